vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 23 ++
 rtl/vram_arbiter_scan_fetch.sv | 57 +++++
 rtl/vram_arbiter.sv | 83 ++++++++
 tb/tb_vram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Video timing constants shared by the sync generator, the scan fetch path and
// the VRAM arbiter, plus the arbiter state encoding.
package vram_arbiter_pkg;

  localparam int VT_H_VISIBLE = 256;
  localparam int VT_H_MAX     = 318;
  localparam int VT_V_VISIBLE = 480;
  localparam int VT_V_MAX     = 524;

  // Last in-line group slot is at x=240, so slots stop below 248; the
  // group-0 prefetch for the following line sits in horizontal blanking.
  localparam logic [8:0] VT_FETCH_X_END = 9'd248;
  localparam logic [8:0] VT_FETCH_X_PRE = 9'd310;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCESS   = 2'd1;
  localparam logic [1:0] ST_ACK_WAIT = 2'd2;

  function automatic logic [9:0] vt_next_line(input logic [9:0] y, input logic [9:0] vmax);
    return (y == vmax) ? 10'd0 : y + 10'd1;
  endfunction

endpackage

// File: rtl/vram_arbiter_scan_fetch.sv
// Scan fetch path: decides scan slots, buffers the fetched byte and shifts
// pixels out MSB first.
module scan_fetch
  import vram_arbiter_pkg::*;
#(
  parameter int H_VISIBLE = VT_H_VISIBLE,
  parameter int H_MAX     = VT_H_MAX,
  parameter int V_VISIBLE = VT_V_VISIBLE,
  parameter int V_MAX     = VT_V_MAX,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        pixel_x_i,
  input  logic [9:0]        pixel_y_i,
  input  logic              video_on_i,
  input  logic [7:0]        ram_rdata_i,
  output logic              slot_o,
  output logic [ADDR_W-1:0] slot_addr_o,
  output logic              pixel_o
);

  logic [9:0] nxt_line;
  logic [8:0] line;
  logic [4:0] grp;
  logic       line_slot, pre_slot, load;
  logic       slot_q;
  logic [7:0] fbuf_q, shift_q;

  assign nxt_line    = vt_next_line(pixel_y_i, 10'(V_MAX));
  assign line_slot   = (pixel_x_i[2:0] == 3'd0) && (pixel_x_i < VT_FETCH_X_END) &&
                       (pixel_y_i < 10'(V_VISIBLE));
  assign pre_slot    = (pixel_x_i == VT_FETCH_X_PRE) && (nxt_line < 10'(V_VISIBLE));
  assign slot_o      = line_slot || pre_slot;
  assign line        = pre_slot ? nxt_line[8:0] : pixel_y_i[8:0];
  assign grp         = pre_slot ? 5'd0 : pixel_x_i[7:3] + 5'd1;
  assign slot_addr_o = ADDR_W'({line, grp});

  // Group g is loaded on the edge ending x=8g-1; group 0 wraps in at H_MAX.
  assign load = ((pixel_x_i[2:0] == 3'd7) && (pixel_x_i < 9'(H_VISIBLE - 1))) ||
                (pixel_x_i == 9'(H_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q  <= 1'b0;
      fbuf_q  <= 8'd0;
      shift_q <= 8'd0;
    end else begin
      slot_q <= slot_o;
      if (slot_q) fbuf_q <= ram_rdata_i;
      shift_q <= load ? fbuf_q : {shift_q[6:0], 1'b0};
    end
  end

  assign pixel_o = shift_q[7] && video_on_i;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan fetch has priority, the host gets the next
// free cycle and sees a one-cycle ack with read data.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int H_VISIBLE = VT_H_VISIBLE,
  parameter int H_MAX     = VT_H_MAX,
  parameter int V_VISIBLE = VT_V_VISIBLE,
  parameter int V_MAX     = VT_V_MAX,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              pixel_out
);

  logic [1:0]        state_q, state_d;
  logic              scan_slot, scan_bus, grant;
  logic [ADDR_W-1:0] scan_addr, ram_addr_q;
  logic [7:0]        ram_wdata_q, host_rdata_q;

  scan_fetch #(
    .H_VISIBLE(H_VISIBLE), .H_MAX(H_MAX), .V_VISIBLE(V_VISIBLE),
    .V_MAX(V_MAX), .ADDR_W(ADDR_W)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .pixel_x_i  (pixel_x),
    .pixel_y_i  (pixel_y),
    .video_on_i (video_on),
    .ram_rdata_i(ram_rdata),
    .slot_o     (scan_slot),
    .slot_addr_o(scan_addr),
    .pixel_o    (pixel_out)
  );

  // The bus is driven in the decision cycle so a host read returns during ack.
  assign scan_bus   = reset && scan_slot;
  assign grant      = reset && (state_q == ST_IDLE) && host_req && !scan_slot;
  assign ram_addr   = scan_bus ? scan_addr : (grant ? host_addr : ram_addr_q);
  assign ram_we     = grant && host_we;
  assign ram_wdata  = grant ? host_wdata : ram_wdata_q;
  assign host_ack   = reset && (state_q == ST_ACCESS);
  assign host_rdata = (host_ack && !host_we) ? ram_rdata : host_rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (grant) state_d = ST_ACCESS;
      ST_ACCESS:   state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: if (!host_req) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'd0;
      host_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr;
      ram_wdata_q <= ram_wdata;
      if (host_ack && !host_we) host_rdata_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: bench-side sync generator and VRAM, directed
// vectors and a random host/pixel run against a spec-level model.
module tb_vram_arbiter;

  localparam logic [8:0] HMAX = 9'd318;
  localparam logic [9:0] VMAX = 10'd524;

  logic        clk, reset;
  logic [8:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on, host_req, host_we;
  logic [13:0] host_addr, ram_addr;
  logic [7:0]  host_wdata, host_rdata, ram_wdata, ram_rdata;
  logic        host_ack, ram_we, pixel_out;

  logic [7:0]  mem    [0:16383];
  logic [7:0]  shadow [0:16383];
  int nvec, nbad;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pixel_out(pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  x;
    logic [9:0]  y;
    logic        we;
    logic [13:0] addr;
    logic [13:0] exp_addr;
    logic        exp_we;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic set_pos(input logic [8:0] x, input logic [9:0] y);
    pixel_x  = x;
    pixel_y  = y;
    video_on = (x < 9'd256) && (y < 10'd480);
  endtask

  // One pixel clock: sample the bus at negedge, model the synchronous VRAM
  // after the edge, then advance the sync counters.
  task automatic step();
    logic [13:0] a;
    logic        w;
    logic [7:0]  d, rd;
    @(negedge clk);
    a = ram_addr; w = ram_we; d = ram_wdata;
    @(posedge clk);
    #1;
    rd = mem[a];
    if (w) mem[a] = d;
    ram_rdata = rd;
    if (pixel_x == HMAX) set_pos(9'd0, (pixel_y == VMAX) ? 10'd0 : pixel_y + 10'd1);
    else                 set_pos(pixel_x + 9'd1, pixel_y);
    #1;
  endtask

  task automatic run_to(input logic [8:0] x, input logic [9:0] y, input string nm);
    int k;
    k = 0;
    while (!(pixel_x == x && pixel_y == y) && k < 2000) begin step(); k++; end
    chk(nm, {pixel_y, pixel_x}, {y, x});
  endtask

  function automatic logic model_px(input int x, input int y);
    logic [7:0] b;
    if (x >= 256 || y >= 480) return 1'b0;
    b = shadow[y * 32 + x / 8];
    return b[7 - x % 8];
  endfunction

  function automatic int model_slot(input int x, input int y);
    int n;
    n = (y == 524) ? 0 : y + 1;
    return ((x % 8 == 0 && x < 248 && y < 480) || (x == 310 && n < 480)) ? 1 : 0;
  endfunction

  initial begin
    logic [15:0] pat16;
    logic [7:0]  pat8, b;
    int ackc, seen, pend, wt, exp_wt, hold;

    nvec = 0; nbad = 0;
    for (int i = 0; i < 16384; i++) begin mem[i] = 8'd0; shadow[i] = 8'd0; end
    ram_rdata = 8'd0;

    // Reset with a pending write request: nothing may reach the bus.
    reset = 1'b0; set_pos(9'd100, 10'd0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h1555; host_wdata = 8'hAB;
    step(); step();
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 14'd0);
    chk("rst_ram_wdata", ram_wdata, 8'd0);
    chk("rst_host_ack", host_ack, 1'b0);
    chk("rst_host_rdata", host_rdata, 8'd0);
    chk("rst_pixel_out", pixel_out, 1'b0);
    host_req = 1'b0; reset = 1'b1;
    step(); step();

    // Single-cycle arbitration vectors taken from the IDLE state.
    tbl[0] = '{9'd0,   10'd5,   1'b1, 14'h2AAA, 14'd161,   1'b0};
    tbl[1] = '{9'd8,   10'd5,   1'b1, 14'h2AAA, 14'd162,   1'b0};
    tbl[2] = '{9'd240, 10'd5,   1'b1, 14'h2AAA, 14'd191,   1'b0};
    tbl[3] = '{9'd248, 10'd5,   1'b1, 14'h0777, 14'h0777,  1'b1};
    tbl[4] = '{9'd310, 10'd5,   1'b1, 14'h2AAA, 14'd192,   1'b0};
    tbl[5] = '{9'd310, 10'd524, 1'b1, 14'h2AAA, 14'd0,     1'b0};
    tbl[6] = '{9'd310, 10'd479, 1'b0, 14'h1111, 14'h1111,  1'b0};
    tbl[7] = '{9'd0,   10'd480, 1'b1, 14'h2222, 14'h2222,  1'b1};
    tbl[8] = '{9'd3,   10'd5,   1'b1, 14'h3FFF, 14'h3FFF,  1'b1};
    tbl[9] = '{9'd16,  10'd479, 1'b1, 14'h2AAA, 14'd15331, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_pos(tbl[i].x, tbl[i].y);
      host_req = 1'b1; host_we = tbl[i].we; host_addr = tbl[i].addr; host_wdata = 8'h99;
      #1;
      chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].exp_we);
      host_req = 1'b0;
      step();
    end
    step();

    // Request coinciding with the x=8 slot: scan first, host next, ack after.
    mem[14'h100] = 8'h77; shadow[14'h100] = 8'h77;
    set_pos(9'd8, 10'd3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0100;
    #1;
    chk("r41_slot_addr", ram_addr, 14'd98);
    chk("r41_slot_ack", host_ack, 1'b0);
    step();
    chk("r41_grant_addr", ram_addr, 14'h0100);
    chk("r41_grant_ack", host_ack, 1'b0);
    step();
    chk("r41_ack", host_ack, 1'b1);
    chk("r41_rdata", host_rdata, 8'h77);
    host_req = 1'b0;
    step();
    chk("r41_ack_gone", host_ack, 1'b0);
    step();

    // Host write at x=100, then line 2 group 0 shows the written byte.
    set_pos(9'd100, 10'd1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0040; host_wdata = 8'h3C;
    #1;
    chk("r40_we", ram_we, 1'b1);
    chk("r40_addr", ram_addr, 14'h0040);
    chk("r40_wdata", ram_wdata, 8'h3C);
    step();
    chk("r40_ack", host_ack, 1'b1);
    chk("r40_we_off", ram_we, 1'b0);
    host_req = 1'b0; shadow[14'h40] = 8'h3C;
    run_to(9'd0, 10'd2, "r40_reach_line2");
    pat8 = 8'b0011_1100;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r40_px%0d", i), pixel_out, pat8[7 - i]);
      step();
    end

    // Read held well past ack: one ack, data valid during it.
    mem[14'h1234] = 8'h5A; shadow[14'h1234] = 8'h5A;
    set_pos(9'd260, 10'd3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h1234;
    #1;
    ackc = 0; seen = -1;
    for (int c = 0; c < 10; c++) begin
      if (host_ack) begin
        ackc++;
        chk("r42_rdata", host_rdata, 8'h5A);
        if (seen < 0) seen = c;
      end
      if (seen >= 0 && c == seen + 5) host_req = 1'b0;
      step();
    end
    chk("r42_ack_count", ackc, 1);

    // Last visible line: no prefetch at x=310, host goes straight through.
    set_pos(9'd310, 10'd479);
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0123;
    #1;
    chk("r43_grant_addr", ram_addr, 14'h0123);
    step();
    chk("r43_ack", host_ack, 1'b1);
    host_req = 1'b0;
    step();

    // Line 0 of the new frame, prefetched at the last line of the old one.
    for (int i = 0; i < 32; i++) begin
      b = (i % 2 == 0) ? 8'hA5 : 8'hFF;
      mem[i] = b; shadow[i] = b;
    end
    set_pos(9'd300, VMAX);
    step();
    run_to(9'd0, 10'd0, "r39_reach_line0");
    pat16 = 16'hA5FF;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("r39_px%0d", i), pixel_out, pat16[15 - i]);
      step();
    end

    // Reset during ACCESS aborts the ack; afterwards the FSM grants again.
    set_pos(9'd50, 10'd3);
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h3000; host_wdata = 8'h11;
    shadow[14'h3000] = 8'h11;
    #1;
    chk("r44_grant", ram_we, 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk("r44_no_ack_a", host_ack, 1'b0);
    step();
    chk("r44_no_ack_b", host_ack, 1'b0);
    chk("r44_pixel", pixel_out, 1'b0);
    reset = 1'b1;
    #1;
    chk("r44_idle_grant", ram_we, 1'b1);
    chk("r44_idle_addr", ram_addr, 14'h3000);
    step();
    chk("r44_ack_after", host_ack, 1'b1);
    host_req = 1'b0;
    step(); step();

    // Random host traffic above line 63 while lines 0..3 are displayed.
    for (int i = 0; i < 128; i++) begin
      b = 8'($urandom); mem[i] = b; shadow[i] = b;
    end
    set_pos(9'd290, VMAX);
    pend = 0; wt = 0; exp_wt = 0; hold = -1;
    for (int c = 0; c < 1300; c++) begin
      if (pend == 0 && $urandom_range(0, 3) == 0) begin
        pend = 1; wt = 0; hold = -1;
        host_we = 1'($urandom); host_addr = 14'($urandom_range(2048, 16383));
        host_wdata = 8'($urandom); host_req = 1'b1;
        exp_wt = model_slot(pixel_x, pixel_y) + 1;
      end
      #1;
      chk("rnd_pixel", pixel_out, model_px(pixel_x, pixel_y));
      if (ram_we) begin
        chk("rnd_waddr", ram_addr, host_addr);
        chk("rnd_wdata", ram_wdata, host_wdata);
      end
      if (pend != 0) begin
        if (hold < 0) begin
          if (host_ack) begin
            chk("rnd_ack_lat", wt, exp_wt);
            if (!host_we) chk("rnd_rdata", host_rdata, shadow[host_addr]);
            else shadow[host_addr] = host_wdata;
            hold = $urandom_range(0, 2);
          end else if (wt > 3) begin
            chk("rnd_ack_timeout", host_ack, 1'b1);
            pend = 0; host_req = 1'b0;
          end
          wt++;
        end else begin
          chk("rnd_single_ack", host_ack, 1'b0);
          if (hold == 0) begin host_req = 1'b0; pend = 0; end
          else hold--;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
